// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared types and widths for the core-to-RAM port controller.
package mem_port_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;
   localparam int WAIT_CNT_W = 4;
   localparam int STAT_W     = 16;
endpackage

// File: rtl/mem_sat_counter.sv
// mem_sat_counter: up-counter that sticks at all-ones, cleared by asynchronous active-low reset.
module mem_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + W'(1);
   end
endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: one-word-at-a-time port from the CPU core onto a single-port RAM with 1-cycle read latency.
// Define MEM_PORT_CTRL_STATS_EN to add saturating read/write/error counters.
module mem_port_ctrl
   import mem_port_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              err,
   output logic              busy,
   output logic [1:0]        state_out,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
`ifdef MEM_PORT_CTRL_STATS_EN
   ,
   output logic [STAT_W-1:0] rd_cnt,
   output logic [STAT_W-1:0] wr_cnt,
   output logic [STAT_W-1:0] err_cnt
`endif
);
   state_t                r_state, w_next;
   logic [WAIT_CNT_W-1:0] r_cnt;
   logic                  r_we_q, r_first;
   logic                  w_bad;

   assign w_bad     = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
   assign busy      = r_state != IDLE;
   assign state_out = r_state;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (req) w_next = w_bad ? RESP : ACCESS;
         ACCESS:  w_next = WAIT;
         WAIT:    if (r_cnt == '0) w_next = RESP;
         default: w_next = IDLE;
      endcase
   end

   // Strobes are registered from w_next so they line up with the state they belong to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_we_q    <= 1'b0;
         r_first   <= 1'b0;
         rdata     <= '0;
         ready     <= 1'b0;
         err       <= 1'b0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         r_state <= w_next;
         r_first <= r_state == ACCESS;
         ram_en  <= w_next == ACCESS;
         ram_we  <= w_next == ACCESS && we;
         ready   <= w_next == RESP;
         err     <= w_next == RESP && r_state == IDLE;
         if (r_state == IDLE && req) begin
            r_we_q    <= we;
            ram_addr  <= addr[ADDR_W+1:2];
            ram_wdata <= wdata;
            if (w_bad) rdata <= '0;
         end
         if (r_state == ACCESS) r_cnt <= WAIT_CNT_W'(WAIT_CYCLES);
         else if (r_state == WAIT && r_cnt != '0) r_cnt <= r_cnt - WAIT_CNT_W'(1);
         if (r_state == WAIT && r_first && !r_we_q) rdata <= ram_rdata;
      end
   end

`ifdef MEM_PORT_CTRL_STATS_EN
   logic w_ok;
   assign w_ok = ready && !err;
   mem_sat_counter #(.W(STAT_W)) u_rd_cnt  (.clk(clk), .rst(rst), .inc(w_ok && !r_we_q), .cnt(rd_cnt));
   mem_sat_counter #(.W(STAT_W)) u_wr_cnt  (.clk(clk), .rst(rst), .inc(w_ok && r_we_q),  .cnt(wr_cnt));
   mem_sat_counter #(.W(STAT_W)) u_err_cnt (.clk(clk), .rst(rst), .inc(ready && err),    .cnt(err_cnt));
`else
   // plain build: no statistics counters
`endif
endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: directed bench for mem_port_ctrl (WAIT_CYCLES 1 and 0) against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_ctrl;
   localparam int AW = 10;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   logic        req_a [2];
   logic        we_a [2];
   logic [31:0] addr_a [2];
   logic [31:0] wdata_a [2];
   logic [31:0] rdata_a [2];
   logic        rdy_a [2];
   logic        err_a [2];
   logic [1:0]  st_a [2];
   logic        sat_inc = 1'b0;
   logic [3:0]  sat_cnt;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      n_tests++;
      if (act !== req_v) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req_v);
      end
   endtask

   task automatic drive(input int g, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      req_a[g] = r; we_a[g] = w; addr_a[g] = a; wdata_a[g] = d;
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_port
      localparam int WC = 1 - g;
      logic          busy, ram_en, ram_we;
      logic [AW-1:0] ram_addr;
      logic [31:0]   ram_wdata, ram_rdata;
      logic [31:0]   ram [1<<AW];
      logic [31:0]   sh [1<<AW];
`ifdef MEM_PORT_CTRL_STATS_EN
      logic [15:0]   rd_cnt, wr_cnt, err_cnt;
`endif
      mem_port_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(WC)) u_dut (
         .clk(clk), .rst(rst), .req(req_a[g]), .we(we_a[g]), .addr(addr_a[g]), .wdata(wdata_a[g]),
         .rdata(rdata_a[g]), .ready(rdy_a[g]), .err(err_a[g]), .busy(busy), .state_out(st_a[g]),
         .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef MEM_PORT_CTRL_STATS_EN
         , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt)
`endif
      );

      initial for (int i = 0; i < (1 << AW); i++) begin ram[i] = '0; sh[i] = '0; end

      always @(posedge clk) if (ram_en) begin
         ram_rdata <= ram[ram_addr];
         if (ram_we) ram[ram_addr] = ram_wdata;
      end

      // Model: a request accepted at edge c owns cycles c..t_rdy; RAM access is cycle c, response cycle c+2+WC.
      int          cyc = 0, t_en = -1, t_rdy = -1;
      bit          pend = 0, m_bad = 0, m_we = 0;
      int unsigned m_a = 0;
      logic [31:0] m_wd = '0, m_exp = '0;
      always @(posedge clk) begin
         cyc++;
         if (!rst) begin
            pend = 0; t_en = -1; t_rdy = -1; m_exp = '0;
         end else if (pend) begin
            if (cyc == t_en + 1 && m_we) sh[m_a] = m_wd;
            if (cyc == t_rdy + 1) pend = 0;
         end else if (req_a[g]) begin
            pend  = 1;
            m_we  = we_a[g];
            m_wd  = wdata_a[g];
            m_a   = (addr_a[g] / 4) % (1 << AW);
            m_bad = (addr_a[g] % 4 != 0) || (addr_a[g] >= 32'(4 << AW));
            t_en  = m_bad ? -1 : cyc;
            t_rdy = m_bad ? cyc : cyc + 2 + WC;
            m_exp = m_bad ? 32'd0 : (m_we ? m_exp : sh[m_a]);
         end
      end

      always @(negedge clk) begin
         logic [4:0] a_ctl, e_ctl;
         a_ctl = {rdy_a[g], err_a[g], busy, ram_en, ram_we};
         e_ctl = rst ? {pend && cyc == t_rdy, pend && cyc == t_rdy && m_bad, pend,
                        pend && cyc == t_en, pend && cyc == t_en && m_we} : 5'b0;
         chk($sformatf("p%0d ctl{rdy,err,busy,en,we}", g), 32'(a_ctl), 32'(e_ctl));
         if (!rst)
            chk($sformatf("p%0d reset regs", g), rdata_a[g] | ram_wdata | 32'(ram_addr) | 32'(st_a[g]), 32'd0);
         else begin
            if (e_ctl[4]) chk($sformatf("p%0d rdata", g), rdata_a[g], m_exp);
            if (e_ctl[1]) chk($sformatf("p%0d ram_addr", g), 32'(ram_addr), m_a);
            if (e_ctl[0]) chk($sformatf("p%0d ram_wdata", g), ram_wdata, m_wd);
         end
      end
   end

   mem_sat_counter #(.W(4)) u_sat (.clk(clk), .rst(rst), .inc(sat_inc), .cnt(sat_cnt));

   task automatic txn(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int e_off, input logic e_err, input logic [31:0] e_rd);
      int off;
      off = -1;
      @(negedge clk);
      drive(g, 1'b1, w, a, d);
      for (int k = 1; k <= 30 && off < 0; k++) begin
         @(negedge clk);
         if (rdy_a[g]) off = k;
      end
      drive(g, 1'b0, 1'b0, '0, '0);
      chk($sformatf("p%0d latency @%h", g, a), 32'(off), 32'(e_off));
      chk($sformatf("p%0d err @%h", g, a), 32'(err_a[g]), 32'(e_err));
      if (!w || e_err) chk($sformatf("p%0d read @%h", g, a), rdata_a[g], e_rd);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t1, t2;
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      // request held during reset must be ignored until release
      drive(0, 1'b1, 1'b0, 32'h10, '0);
      repeat (3) @(negedge clk);
      chk("reset state", 32'(st_a[0]), 32'd0);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("first edge after reset -> ACCESS", 32'(st_a[0]), 32'd1);
      for (int k = 0; k < 10 && !rdy_a[0]; k++) @(negedge clk);
      chk("post-reset read ready", 32'(rdy_a[0]), 32'd1);
      drive(0, 1'b0, 1'b0, '0, '0);

      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4, 1'b0, '0);
      txn(0, 1'b0, 32'h10, '0, 4, 1'b0, 32'hDEADBEEF);
      txn(0, 1'b0, 32'h2, '0, 1, 1'b1, 32'd0);
      txn(0, 1'b0, 32'h1000, '0, 1, 1'b1, 32'd0);
      txn(0, 1'b1, 32'hFFC, 32'h0BADF00D, 4, 1'b0, '0);
      txn(0, 1'b0, 32'hFFC, '0, 4, 1'b0, 32'h0BADF00D);

      txn(1, 1'b1, 32'h0, 32'hA5A5A5A5, 3, 1'b0, '0);
      txn(1, 1'b1, 32'h4, 32'h12345678, 3, 1'b0, '0);
      txn(1, 1'b0, 32'h4, '0, 3, 1'b0, 32'h12345678);
      @(negedge clk);
      drive(1, 1'b1, 1'b0, 32'h0, '0);
      t1 = -1; t2 = -1;
      for (int k = 1; k <= 20 && t2 < 0; k++) begin
         @(negedge clk);
         if (rdy_a[1]) begin
            if (t1 < 0) begin
               t1 = k;
               chk("b2b first read", rdata_a[1], 32'hA5A5A5A5);
               addr_a[1] = 32'h4;
            end else begin
               t2 = k;
               chk("b2b second read", rdata_a[1], 32'h12345678);
            end
         end
      end
      drive(1, 1'b0, 1'b0, '0, '0);
      chk("b2b first latency", 32'(t1), 32'd3);
      chk("b2b ready spacing", 32'(t2 - t1), 32'd4);

      // reset during WAIT: no ready, but the write already issued to RAM sticks
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
      for (int k = 0; k < 10 && st_a[0] != 2'd2; k++) @(negedge clk);
      chk("reached WAIT", 32'(st_a[0]), 32'd2);
      #2 rst = 1'b0;
      drive(0, 1'b0, 1'b0, '0, '0);
      repeat (3) begin
         @(negedge clk);
         chk("mid-op reset {state,ready}", 32'({st_a[0], rdy_a[0]}), 32'd0);
      end
      #2 rst = 1'b1;
      txn(0, 1'b0, 32'h20, '0, 4, 1'b0, 32'hCAFEF00D);

      txn(0, 1'b1, 32'h30, 32'h11111111, 4, 1'b0, '0);
      txn(0, 1'b1, 32'h34, 32'h22222222, 4, 1'b0, '0);
      txn(0, 1'b0, 32'h30, '0, 4, 1'b0, 32'h11111111);
      txn(0, 1'b0, 32'h34, '0, 4, 1'b0, 32'h22222222);
      txn(0, 1'b0, 32'h3, '0, 1, 1'b1, 32'd0);
      @(negedge clk);
`ifdef MEM_PORT_CTRL_STATS_EN
      chk("rd_cnt", 32'(g_port[0].rd_cnt), 32'd3);
      chk("wr_cnt", 32'(g_port[0].wr_cnt), 32'd2);
      chk("err_cnt", 32'(g_port[0].err_cnt), 32'd1);
`endif

      chk("sat counter reset", 32'(sat_cnt), 32'd0);
      sat_inc = 1'b1;
      repeat (15) @(negedge clk);
      chk("sat counter max", 32'(sat_cnt), 32'd15);
      repeat (2) @(negedge clk);
      chk("sat counter holds", 32'(sat_cnt), 32'd15);
      sat_inc = 1'b0;

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Memory-port controller between the multi-cycle CPU core and its unified instruction/data synchronous RAM. It accepts one word request at a time from the core (instruction fetch or load/store) and drives a single-port RAM with one-cycle read latency. It inserts a parameterised number of wait states and returns data with a one-cycle `ready` pulse. Misaligned and out-of-range addresses are flagged rather than forwarded.

## Interface
Parameters:
- `ADDR_W`, 10: RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 1: extra wait states after data capture; legal range 0–15.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: asynchronous, active-low reset (`rst`=0 resets).
- `req` in 1: core request; held high until `ready`.
- `we` in 1: 1 = write, 0 = read; sampled with `req`.
- `addr` in 32: byte address from the core.
- `wdata` in 32: write data.
- `rdata` out 32: registered read data.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: valid with `ready`; 1 = misaligned or out-of-range access.
- `busy` out 1: high when state ≠ IDLE.
- `state_out` out 2: current FSM state, for debug.
- `ram_en` out 1: RAM enable.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM word address, `addr_q[ADDR_W+1:2]`.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid the cycle after `ram_en`.

## Operation
- States:
  - IDLE=0
  - ACCESS=1
  - WAIT=2
  - RESP=3
- IDLE: when `req`=1, latch `addr`, `we` and `wdata` into `addr_q`, `we_q` and `wdata_q`. Go to RESP with `err` set if `addr[1:0]`≠0 or `addr[31:ADDR_W+2]`≠0; otherwise go to ACCESS.
- ACCESS (1 cycle): `ram_en`=1, `ram_we`=`we_q`, `ram_addr` and `ram_wdata` come from the latched values. Load the wait counter with `WAIT_CYCLES`, then go to WAIT.
- WAIT: in the first WAIT cycle, reads latch `rdata`←`ram_rdata`; writes leave `rdata` unchanged. While the counter is ≠0, decrement it and stay; when it is 0, go to RESP. Total WAIT length is 1+`WAIT_CYCLES` cycles.
- RESP (1 cycle): `ready`=1 and `err` is valid, then go to IDLE unconditionally.
- On an error response, `rdata` is forced to 0 and no RAM access occurs.
- `req`, `addr`, `we` and `wdata` are ignored outside IDLE. Changes mid-transaction have no effect.
- If `req` is still high in the IDLE cycle after RESP, a new transaction starts. There is no combinational pass-through.
- `ram_en`, `ram_we`, `ready` and `err` are registered (Moore) outputs of the state.

## Timing
- Reset values:
  - state IDLE
  - `rdata`=0, `ready`=0, `err`=0, `busy`=0
  - `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0
  - wait counter 0
- Latency: `req` sampled at edge n. ACCESS occupies cycle n+1, WAIT occupies n+2 … n+2+`WAIT_CYCLES`, and `ready` is high in cycle n+3+`WAIT_CYCLES`.
- Error latency: `ready` is high in cycle n+1.
- Minimum request spacing: 4+`WAIT_CYCLES` cycles, including the IDLE cycle.
- Reset mid-operation: return to IDLE immediately and pulse no `ready`. A write whose ACCESS cycle already occurred stays committed in RAM.

## Configuration
- `MEM_PORT_CTRL_STATS_EN` defined:
  - Adds outputs `rd_cnt`, `wr_cnt` and `err_cnt` (16 bits each).
  - Each counter saturates at 0xFFFF and is cleared by reset.
  - Each counter increments in the RESP cycle of a successful read, a successful write, or an error response, respectively.
- `MEM_PORT_CTRL_STATS_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Package `mem_port_pkg`:
  - state encoding (IDLE/ACCESS/WAIT/RESP, 2-bit)
  - wait-counter width constant (4)
  - stats-counter width constant (16)
- Sub-module `mem_sat_counter`: width-parameterised saturating counter with `inc` input. It is instantiated three times under `MEM_PORT_CTRL_STATS_EN`.

## Test plan
- Reset: hold `rst`=0 with `req`=1 → all outputs stay at their reset values. Release `rst` → ACCESS follows on the next edge.
- Write then read, `WAIT_CYCLES`=1:
  - Write `addr`=0x10, `wdata`=0xDEADBEEF → `ram_en`=`ram_we`=1 with `ram_addr`=4, and `ready` on cycle n+4.
  - Read back 0x10 → `rdata`=0xDEADBEEF with `ready` on cycle n+4 and `err`=0.
- `WAIT_CYCLES`=0: read → `ready` on cycle n+3. Back-to-back reads of 0x0 and 0x4 with `req` held high → `ready` pulses 4 cycles apart.
- Errors:
  - `addr`=0x2 → `ram_en` never asserts, `ready`=`err`=1 in cycle n+1, `rdata`=0.
  - `addr`=0x1000 with `ADDR_W`=10 → same error response.
- Reset mid-operation: assert `rst`=0 during WAIT → no `ready`, state IDLE. A subsequent read returns the data written in the interrupted ACCESS.
- Stats (macro on): 3 reads, 2 writes and 1 misaligned access → `rd_cnt`=3, `wr_cnt`=2, `err_cnt`=1. Forcing 0xFFFF+1 increments leaves the counter at 0xFFFF.
